// File: rtl/mkio_manchester_tx.sv
// mkio_manchester_tx: MIL-STD-1553 (MKIO) Manchester-II word transmitter.
//
// Serialises each captured 16-bit word as a 40 half-bit frame: 6 half-bits of sync
// (command/status: +++---, data: ---+++), 16 data bits MSB first (1 = +-, 0 = -+) and an
// odd-parity bit encoded like a data bit. A one-word holding register lets a second word
// follow the first with no gap on the bus.
//
// Optional feature: define MKIO_TX_WDT_EN to enable the continuous-transmission watchdog.
// Once tx_en has been high for WDT_CLKS cycles, the transmitter is forced idle, the holding
// register is cleared and tx_timeout latches high until reset.
//
// Parameters:
//   HALF_BIT_CLKS  clk cycles per half-bit (>= 2)
//   WDT_CLKS       watchdog limit in clk cycles of continuous tx_en
//
// Ports:
//   clk         system clock
//   reset       asynchronous active-low reset
//   tx_data     word to send, sampled in the capture cycle
//   tx_cd       0 = command/status sync, 1 = data sync
//   tx_ready    load request (level; one capture per rising edge)
//   tx_busy     word shifting or holding register full
//   tx_p/tx_n   differential phases to the bus driver
//   tx_en       bus driver enable
//   tx_drop     1-cycle pulse: request lost, holding register was full
//   tx_timeout  sticky watchdog flag (tied 0 without MKIO_TX_WDT_EN)
module mkio_manchester_tx #(
  parameter int unsigned HALF_BIT_CLKS = 16,
  parameter int unsigned WDT_CLKS      = 25600
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] tx_data,
  input  logic        tx_cd,
  input  logic        tx_ready,
  output logic        tx_busy,
  output logic        tx_p,
  output logic        tx_n,
  output logic        tx_en,
  output logic        tx_drop,
  output logic        tx_timeout
);

  localparam int unsigned BaudW = (HALF_BIT_CLKS > 1) ? $clog2(HALF_BIT_CLKS) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(HALF_BIT_CLKS - 1);
  localparam logic [5:0] HalfLast = 6'd39;

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e            state_q, state_d;
  logic [BaudW-1:0]  baud_q, baud_d;
  logic [5:0]        half_q, half_d;
  logic [16:0]       word_q, word_d;     // {cd, data} of the word on the bus
  logic [16:0]       hold_q, hold_d;     // {cd, data} waiting for the shifter
  logic              hold_full_q, hold_full_d;
  logic              ready_q;
  logic              drop_q, drop_d;

  logic              capture;
  logic              half_end;
  logic              frame_end;
  logic              abort;
  logic              timed_out;

  logic [3:0]        bit_idx;
  logic              sym_plus;

  // Watchdog on continuous driver enable
`ifdef MKIO_TX_WDT_EN
  localparam int unsigned WdtW = $clog2(WDT_CLKS + 1);
  localparam logic [WdtW-1:0] WdtLast = WdtW'(WDT_CLKS - 1);

  logic [WdtW-1:0] wdt_q;
  logic            timeout_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (!tx_en) begin
        wdt_q <= '0;
      end else begin
        wdt_q <= wdt_q + 1'b1;
      end
      if (abort) begin
        timeout_q <= 1'b1;
      end
    end
  end

  // Fires in the WDT_CLKS-th consecutive cycle of tx_en
  assign abort     = tx_en && (wdt_q == WdtLast);
  assign timed_out = timeout_q;
`else
  assign abort     = 1'b0;
  assign timed_out = 1'b0;
`endif

  // Rising-edge detect on tx_ready; requests are ignored once the watchdog has tripped
  assign capture   = tx_ready & ~ready_q & ~timed_out;
  assign half_end  = (state_q == StShift) && (baud_q == BaudLast);
  assign frame_end = half_end && (half_q == HalfLast);

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    half_d      = half_q;
    word_d      = word_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    drop_d      = 1'b0;

    if (capture) begin
      if (state_q == StIdle) begin
        state_d = StShift;
        baud_d  = '0;
        half_d  = '0;
        word_d  = {tx_cd, tx_data};
      end else if (hold_full_q) begin
        drop_d = 1'b1;
      end else begin
        hold_d      = {tx_cd, tx_data};
        hold_full_d = 1'b1;
      end
    end

    if (state_q == StShift) begin
      if (!half_end) begin
        baud_d = baud_q + 1'b1;
      end else if (!frame_end) begin
        baud_d = '0;
        half_d = half_q + 6'd1;
      end else if (hold_full_d) begin
        // hold_d/hold_full_d include a capture made in this very cycle, so a word
        // requested as the last half-bit ends still follows without a gap
        baud_d      = '0;
        half_d      = '0;
        word_d      = hold_d;
        hold_full_d = 1'b0;
      end else begin
        state_d = StIdle;
        baud_d  = '0;
        half_d  = '0;
      end
    end

    if (abort) begin
      state_d     = StIdle;
      baud_d      = '0;
      half_d      = '0;
      hold_full_d = 1'b0;
      drop_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      baud_q      <= '0;
      half_q      <= '0;
      word_q      <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      half_q      <= half_d;
      word_q      <= word_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ready_q     <= tx_ready;
      drop_q      <= drop_d;
    end
  end

  // Symbol of the current half-bit: 1 = '+', 0 = '-'.
  // Data half-bit 6 + 2k carries bit 15-k; the odd half-bit of each pair is the complement.
  always_comb begin
    bit_idx = 4'd15 - 4'((half_q - 6'd6) >> 1);
    if (half_q < 6'd6) begin
      sym_plus = (half_q < 6'd3) ^ word_q[16];
    end else if (half_q < 6'd38) begin
      sym_plus = word_q[bit_idx] ^ half_q[0];
    end else begin
      sym_plus = (~^word_q[15:0]) ^ half_q[0];
    end
  end

  assign tx_en      = (state_q == StShift);
  assign tx_p       = tx_en & sym_plus;
  assign tx_n       = tx_en & ~sym_plus;
  assign tx_busy    = tx_en | hold_full_q;
  assign tx_drop    = drop_q;
  assign tx_timeout = timed_out;

endmodule
